// File: rtl/nios2os_irq_ctrl.sv
// rtl/nios2os_irq_ctrl.sv - Avalon-MM interrupt aggregator with per-source level/edge latching, mask and priority encoder
// Optional: define NIOS2OS_IRQ_CTRL_SYNC_EN to add a 2-flop synchroniser on every irq_in bit.
module nios2os_irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               irq_out
);

    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] mode;
    logic [NUM_SRC-1:0] overflow;
    logic [NUM_SRC-1:0] pend_clr;
    logic [NUM_SRC-1:0] ovf_clr;
    logic [NUM_SRC-1:0] active_vec;
    logic [NUM_SRC-1:0] wdata;
    logic               wr_en;
    logic               act_valid;
    logic [3:0]         act_idx;
    logic [15:0]        rd_mux;

    function automatic logic [15:0] ext16(input logic [NUM_SRC-1:0] v);
        ext16 = '0;
        ext16[NUM_SRC-1:0] = v;
    endfunction

`ifdef NIOS2OS_IRQ_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] sync_q1;
    logic [NUM_SRC-1:0] sync_q2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_in;
            sync_q2 <= sync_q1;
        end
    end

    assign src = sync_q2;
`else
    assign src = irq_in;
`endif

    assign wr_en    = chipselect && !write_n;
    assign wdata    = writedata[NUM_SRC-1:0];
    assign rise     = src & ~prev;
    assign pend_clr = (wr_en && address == 3'd0) ? wdata : '0;
    assign ovf_clr  = (wr_en && address == 3'd4) ? wdata : '0;
    assign active_vec = pending & mask;

    // Edge bits: a rise beats a same-cycle clear. Level bits simply follow src.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev     <= '0;
            pending  <= '0;
            overflow <= '0;
            mask     <= '0;
            mode     <= '0;
            irq_out  <= 1'b0;
        end else begin
            prev     <= src;
            pending  <= (mode & ((pending & ~pend_clr) | rise)) | (~mode & src);
            overflow <= (overflow & ~ovf_clr) | (rise & mode & pending);
            irq_out  <= |active_vec;
            if (wr_en && address == 3'd1) begin
                mask <= wdata;
            end
            if (wr_en && address == 3'd2) begin
                mode <= wdata;
            end
        end
    end

    always_comb begin
        act_valid = 1'b0;
        act_idx   = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active_vec[i]) begin
                act_valid = 1'b1;
                act_idx   = 4'(i);
            end
        end
    end

    always_comb begin
        rd_mux = 16'h0000;
        case (address)
            3'd0:    rd_mux = ext16(pending);
            3'd1:    rd_mux = ext16(mask);
            3'd2:    rd_mux = ext16(mode);
            3'd3:    rd_mux = {act_valid, 11'b0, act_idx};
            3'd4:    rd_mux = ext16(overflow);
            default: rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 16'h0000;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_nios2os_irq_ctrl.sv
// tb/tb_nios2os_irq_ctrl.sv - directed self-checking bench for nios2os_irq_ctrl (default build)
module tb_nios2os_irq_ctrl;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [7:0]  irq_in;
    logic        irq_out;

    int vec_cnt;
    int err_cnt;
    logic [15:0] rv;

    nios2os_irq_ctrl #(.NUM_SRC(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq_out    (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [15:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    initial begin
        vec_cnt    = 0;
        err_cnt    = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0000;
        irq_in     = 8'h00;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        for (int a = 0; a < 8; a++) begin
            reg_rd(3'(a), rv);
            check($sformatf("reset_rd%0d", a), rv, 16'h0000);
        end
        check("reset_irq", {15'b0, irq_out}, 16'h0000);

        // Edge mode on source 0, single-cycle pulse
        reg_wr(3'd2, 16'h0001);
        reg_wr(3'd1, 16'h0001);
        address = 3'd3;
        irq_in  = 8'h01;
        tick();
        irq_in = 8'h00;
        check("edge_irq_n1", {15'b0, irq_out}, 16'h0000);
        tick();
        check("edge_irq_n2", {15'b0, irq_out}, 16'h0001);
        check("edge_active", readdata, 16'h8000);
        reg_rd(3'd0, rv);
        check("edge_pending", rv, 16'h0001);
        reg_wr(3'd0, 16'h0001);
        check("edge_clr_irq1", {15'b0, irq_out}, 16'h0001);
        tick();
        check("edge_clr_irq2", {15'b0, irq_out}, 16'h0000);

        // Level mode, priority and masking
        reg_wr(3'd2, 16'h0000);
        reg_wr(3'd1, 16'h00FF);
        irq_in = 8'h24;
        tick();
        reg_rd(3'd3, rv);
        check("lvl_active2", rv, 16'h8002);
        reg_wr(3'd1, 16'h0020);
        reg_rd(3'd3, rv);
        check("lvl_active5", rv, 16'h8005);
        irq_in = 8'h00;
        tick();
        check("lvl_drop_irq1", {15'b0, irq_out}, 16'h0001);
        tick();
        check("lvl_drop_irq2", {15'b0, irq_out}, 16'h0000);
        reg_rd(3'd3, rv);
        check("lvl_active_none", rv, 16'h0000);

        // Overflow on source 3
        reg_wr(3'd2, 16'h0008);
        reg_wr(3'd1, 16'h0008);
        irq_in = 8'h08; tick();
        irq_in = 8'h00; tick();
        irq_in = 8'h08; tick();
        irq_in = 8'h00; tick();
        reg_rd(3'd4, rv);
        check("ovf_set", rv, 16'h0008);
        reg_wr(3'd4, 16'h0008);
        reg_rd(3'd4, rv);
        check("ovf_clr", rv, 16'h0000);
        reg_rd(3'd0, rv);
        check("ovf_pending", rv, 16'h0008);

        // Rise on source 1 in the same cycle as its PENDING clear
        reg_wr(3'd2, 16'h000A);
        irq_in = 8'h02;
        reg_wr(3'd0, 16'h0002);
        irq_in = 8'h00;
        reg_rd(3'd0, rv);
        check("set_beats_clr", rv, 16'h000A);
        reg_wr(3'd0, 16'h0002);
        reg_rd(3'd0, rv);
        check("edge_clr1", rv, 16'h0008);

        // Level bit ignores PENDING write; level->edge switch holds value
        irq_in = 8'h10;
        tick();
        reg_wr(3'd0, 16'h0010);
        reg_rd(3'd0, rv);
        check("lvl_no_clr", rv, 16'h0018);
        reg_wr(3'd2, 16'h001A);
        irq_in = 8'h00;
        tick();
        reg_rd(3'd0, rv);
        check("lvl2edge_hold", rv, 16'h0018);

        // Unimplemented bits and addresses
        reg_wr(3'd1, 16'hFFFF);
        reg_rd(3'd1, rv);
        check("mask_width", rv, 16'h00FF);
        reg_wr(3'd5, 16'hFFFF);
        reg_rd(3'd5, rv);
        check("addr5_zero", rv, 16'h0000);

        // Reset mid-operation discards latched events
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        reg_rd(3'd0, rv);
        check("rst_pending", rv, 16'h0000);
        reg_rd(3'd1, rv);
        check("rst_mask", rv, 16'h0000);
        check("rst_irq", {15'b0, irq_out}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
